scan_sequencer: RTL
===================

# scan_sequencer

Free-running channel sequencer that generates the 2-bit select code driven into the team's 2-to-4 one-hot decoder. It cycles a select value through up to four channels at a programmable rate, skips masked channels, and supports run/pause/single-step control. It sits directly upstream of the decoder: `sel[0]` drives decoder `inp1` and `sel[1]` drives decoder `inp2`. Typical use is multiplexed display or LED scanning.

## Interface
- `PRESCALE_W`, default 16: width of the divider input and the internal prescale counter.
- `clk`, input, 1: single clock; all logic is on its rising edge.
- `rst_n`, input, 1: synchronous reset, active-low, sampled on the `clk` rising edge.
- `start`, input, 1: level-sampled request to begin scanning from IDLE.
- `stop`, input, 1: return to IDLE; takes priority over every other input.
- `pause`, input, 1: level; freezes scanning while high.
- `step`, input, 1: single-cycle pulse; advances one channel while in HOLD.
- `dir`, input, 1: 0 = ascending (3 wraps to 0), 1 = descending (0 wraps to 3).
- `div`, input, PRESCALE_W: clock cycles per channel; 0 is treated as 1.
- `mask`, input, 4: channel enables; bit n enables channel n.
- `sel`, output, 2: current channel, registered, feeding the decoder.
- `sel_valid`, output, 1: high while `sel` is meaningful; the decoder outputs are gated with it downstream.
- `tick`, output, 1: one-cycle pulse in the first cycle of each new channel.
- `busy`, output, 1: high in RUN or HOLD.

## Operation
- States: IDLE, RUN, HOLD. Reset forces IDLE, `sel`=0, `sel_valid`=0, `tick`=0, `busy`=0, prescale count=0.
- IDLE:
  - If `start`=1 and `mask`≠0, go to RUN.
  - `sel` loads the lowest enabled channel when `dir`=0, or the highest when `dir`=1.
  - Count clears to 0; `sel_valid`=1.
  - If `mask`=0, `start` is ignored.
- RUN:
  - The count increments each cycle.
  - When count = max(`div`,1)−1, the count clears and `sel` loads the next enabled channel in direction `dir`, with wrap-around. `tick` is 1 in the following cycle.
  - If only one channel is enabled, `sel` is unchanged but `tick` still pulses.
- `mask` and `dir` are sampled only at an advance. Clearing the bit of the current channel takes effect at the next advance.
- If `mask`=0 at an advance, go to IDLE with `sel_valid`=0 and `sel` held.
- RUN with `pause`=1 goes to HOLD; the count freezes.
- HOLD with `pause`=0 goes to RUN and resumes from the frozen count.
- HOLD with `step`=1 advances exactly as in RUN: next channel, `tick` pulse, count cleared to 0.
- `step` outside HOLD is ignored.
- Priority when inputs coincide: `rst_n` > `stop` > `pause` > `step`/advance > `start`.
- `stop` in RUN or HOLD goes to IDLE next cycle: `sel_valid`=0, `busy`=0, `sel` retains its value.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Start latency: `start` sampled at edge E0 gives `sel` valid in the cycle after E0.
- Each channel is held for exactly max(`div`,1) cycles in RUN.
- `tick` is coincident with the first cycle of the new `sel` value.
- A change to `div` mid-channel applies immediately to the terminal compare. If the count is already at or above the new terminal value, the advance happens on the next cycle.
- Reset asserted mid-scan returns all outputs to their reset values at that edge.

## Configuration
- `SCAN_SEQUENCER_BLANK_EN`:
  - Defined: on every advance, `sel_valid` is 0 for the first cycle of the new channel (anti-ghosting blank). `tick` still pulses in that cycle. Channel period is unchanged.
  - Undefined: `sel_valid` stays 1 throughout RUN and HOLD.

## Structure
- Package `scan_pkg`: state encoding (IDLE/RUN/HOLD), `NUM_CH`=4, and `SEL_W`=2.
- Sub-module `scan_next_sel`, purely combinational:
  - Inputs: current `sel`, `mask`, `dir`.
  - Outputs: next enabled channel and a `none` flag.
  - Search is a rotating priority scan.
- The top level holds the FSM, the prescale counter, and the output registers.

## Test plan
- `div`=4, `mask`=1111, `dir`=0, `start` pulse → `sel` = 0,0,0,0,1,1,1,1,2,… wrapping 3→0. `tick` high on the first cycle of each value.
- `mask`=1010, `dir`=1, `div`=2 → after start, `sel` = 3,3,1,1,3,3… Channels 0 and 2 never appear.
- `div`=0, `mask`=1111 → `sel` advances every cycle and `tick` stays high continuously.
- RUN with `div`=5, `pause` raised at count 2, then three `step` pulses, then `pause` released → three single advances with one `tick` each. Resume holds the last channel for a full 5 cycles.
- `stop` and `start` asserted together in RUN → IDLE, `sel_valid`=0, `busy`=0. `rst_n`=0 mid-scan → `sel`=0, all outputs 0 at the next edge.
- With `SCAN_SEQUENCER_BLANK_EN` and `div`=3 → `sel_valid` pattern 1,1,1 for the first channel after start, then 0,1,1 repeating at each advance.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and sizes for the scan sequencer: FSM state encoding and channel geometry.
package scan_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } scan_state_t;

endpackage

// File: rtl/scan_next_sel.sv
// Combinational rotating-priority search for the next enabled channel after cur in direction dir.
module scan_next_sel
  import scan_pkg::*;
(
  input  logic [SEL_W-1:0]  cur,
  input  logic [NUM_CH-1:0] mask,
  input  logic              dir,
  output logic [SEL_W-1:0]  nxt,
  output logic              none
);

  // Candidates are visited cur+1, cur+2, cur+3 and finally cur itself, so a
  // lone enabled channel selects itself again.
  always_comb begin
    logic [SEL_W-1:0] cand;
    cand = '0;
    nxt  = cur;
    none = 1'b1;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = dir ? (cur - SEL_W'(i)) : (cur + SEL_W'(i));
      if (none && mask[cand]) begin
        nxt  = cand;
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Channel scan sequencer driving a 2-to-4 decoder select; run/pause/step control with prescaler.
// Optional SCAN_SEQUENCER_BLANK_EN: blanks sel_valid for the first cycle after each advance.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic                  step,
  input  logic                  dir,
  input  logic [PRESCALE_W-1:0] div,
  input  logic [NUM_CH-1:0]     mask,
  output logic [SEL_W-1:0]      sel,
  output logic                  sel_valid,
  output logic                  tick,
  output logic                  busy
);

  scan_state_t           state, state_d;
  logic [PRESCALE_W-1:0] count, count_d, term;
  logic [SEL_W-1:0]      sel_d, base, nxt;
  logic                  tick_d, valid_d, busy_d;
  logic                  none, adv, go;

  // From IDLE the search starts just "outside" the range so it lands on the
  // lowest (ascending) or highest (descending) enabled channel.
  assign base = (state == ST_IDLE) ? (dir ? SEL_W'(0) : SEL_W'(NUM_CH - 1)) : sel;

  scan_next_sel u_next_sel (
    .cur  (base),
    .mask (mask),
    .dir  (dir),
    .nxt  (nxt),
    .none (none)
  );

  assign term = (div == '0) ? '0 : (div - PRESCALE_W'(1));
  assign go   = !stop && (state == ST_IDLE) && start && !none;
  assign adv  = !stop && (((state == ST_RUN) && !pause && (count >= term)) ||
                          ((state == ST_HOLD) && pause && step));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: if (go) state_d = ST_RUN;
        ST_RUN: begin
          if (pause)            state_d = ST_HOLD;
          else if (adv && none) state_d = ST_IDLE;
        end
        ST_HOLD: begin
          if (!pause)           state_d = ST_RUN;
          else if (adv && none) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    sel_d   = sel;
    count_d = count;
    tick_d  = 1'b0;
    if (stop) begin
      count_d = '0;
    end else if (go) begin
      sel_d   = nxt;
      count_d = '0;
      tick_d  = 1'b1;
    end else if (adv) begin
      count_d = '0;
      if (!none) begin
        sel_d  = nxt;
        tick_d = 1'b1;
      end
    end else if ((state == ST_RUN) && !pause) begin
      count_d = count + PRESCALE_W'(1);
    end
    busy_d = (state_d != ST_IDLE);
`ifdef SCAN_SEQUENCER_BLANK_EN
    valid_d = busy_d && !adv;
`else
    valid_d = busy_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count     <= '0;
      sel       <= '0;
      sel_valid <= 1'b0;
      tick      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      count     <= count_d;
      sel       <= sel_d;
      sel_valid <= valid_d;
      tick      <= tick_d;
      busy      <= busy_d;
    end
  end

endmodule
